uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter between N_REQ result-readout FSMs (dot product, Manhattan, Euclidean, vector readback). Each requester streams a frame of bytes through a valid/ready handshake and marks the final byte with `last`. The arbiter grants one requester at a time, holds the grant for the whole frame, and paces bytes into the transmitter with the `tx_start`/`tx_busy` handshake. It sits between the readout FSMs and `uart_tx`.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `BUSY_TIMEOUT`, default 15: cycles to wait for `tx_busy` to rise after `tx_start` before the byte is treated as sent.
- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `req_valid`  in  N_REQ: requester i presents a byte.
- `req_data`  in  8*N_REQ: byte of requester i in bits [8i+7:8i].
- `req_last`  in  N_REQ: the presented byte is the last of the frame.
- `req_ready`  out  N_REQ: one-cycle pulse; requester i's byte is captured this cycle.
- `grant`  out  N_REQ: one-hot owner of the transmitter; zero when idle.
- `tx_start`  out  1: one-cycle pulse per byte to `uart_tx`.
- `tx_data`  out  8: byte to transmit; stable from capture until the next capture.
- `tx_busy`  in  1: transmitter shifting.
- `frame_done`  out  1: one-cycle pulse after the last byte of a frame completes.
- `frames_sent`  out  16: count of completed frames; wraps 0xFFFF→0.

## Operation
- States: IDLE, ARB, LOAD, SEND, WAIT_HI, WAIT_LO, DONE. All state, grant, data, and counters are registered.
- IDLE: `grant`=0. If any `req_valid`, go to ARB.
- ARB: search from requester (rr_ptr+1) mod N_REQ upward, wrapping. The first requester with `req_valid`=1 wins and is registered as `g` and in `grant`. Go to LOAD. If the valid requester drops in the same cycle, it is still granted.
- LOAD: if `req_valid[g]`, pulse `req_ready[g]`, capture `req_data[g]` into `tx_data` and `req_last[g]` into `last_q`, then go to SEND. Otherwise hold in LOAD with grant kept; a requester may stall mid-frame indefinitely.
- SEND: if `tx_busy`=0, assert `tx_start` this cycle and go to WAIT_HI with the timer cleared. Otherwise hold with `tx_start`=0.
- WAIT_HI: if `tx_busy`=1, go to WAIT_LO. Otherwise increment the timer; when it reaches BUSY_TIMEOUT, go to WAIT_LO.
- WAIT_LO: if `tx_busy`=0, go to DONE when `last_q`=1, else go to LOAD.
- DONE: pulse `frame_done`, increment `frames_sent`, set rr_ptr←g, clear `grant`, go to IDLE.
- `req_ready` is never asserted for a requester that is not granted. At most one bit is set at any time.
- Requests from non-granted requesters are ignored until DONE. There is no pre-emption.
- Frame length is unbounded. A single-byte frame (`last` on the first byte) is legal.

## Timing
- Reset values: state IDLE, `grant`=0, `req_ready`=0, `tx_start`=0, `tx_data`=0x00, `frame_done`=0, `frames_sent`=0, `last_q`=0, timer=0, rr_ptr=N_REQ-1 (requester 0 has first priority after reset).
- Reset asserted mid-frame: all of the above apply immediately and asynchronously. `tx_start` drops the same instant. A byte already in `uart_tx` is not aborted; the arbiter simply does not wait for it.
- Latency, idle and `tx_busy`=0, `req_valid` rising before edge 0:
  - ARB at cycle 1.
  - LOAD at cycle 2, with `req_ready` pulse.
  - SEND at cycle 3, with `tx_start` pulse.
- Inter-byte timing, requester keeping `req_valid` high: the next `req_ready` comes 1 cycle after `tx_busy` falls; the next `tx_start` comes 1 cycle after that.
- `frame_done` is asserted 1 cycle after `tx_busy` falls on the last byte. The next arbitration starts at earliest 2 cycles after `frame_done`.
- Timeout path: with `tx_busy` stuck low, each byte takes 1 (SEND) + BUSY_TIMEOUT (WAIT_HI) + 1 (WAIT_LO) cycles after capture.
- `tx_busy` already high on entering SEND: `tx_start` is withheld until it drops.

## Test plan
- Single requester: req 1 sends a 4-byte frame 0x11,0x22,0x33,0x44 (last on 0x44), model UART busy for 10 cycles.
  - `tx_start` fires 4 times with `tx_data` in that order.
  - `req_ready[1]` pulses 4 times; `grant`=4'b0010 throughout.
  - `frame_done` pulses once; `frames_sent`=1.
- Simultaneous requests: after reset, req 0 and req 2 both valid, each with a 2-byte frame.
  - Req 0's frame is sent completely before any req 2 byte.
  - Then req 2's frame is sent and rr_ptr=2.
- Round-robin fairness: all 4 requesters continuously valid with 1-byte frames. Grant order is 0,1,2,3,0,1 with no requester skipped or repeated.
- Stall and timeout: req 3 drops `req_valid` for 20 cycles between bytes 1 and 2, and `tx_busy` is held 0 throughout.
  - Grant stays on req 3 during the stall; other requests are ignored.
  - Each byte completes after the BUSY_TIMEOUT=15 path.
- Reset mid-frame: pull `reset` low during WAIT_HI of byte 2 of a 3-byte frame.
  - All outputs go to reset values immediately; `frames_sent` returns to 0.
  - After release, a new request is served from requester 0 priority.
- Counter wrap: preload `frames_sent` to 0xFFFF via 65535 one-byte frames (or force), send one more frame, and check `frames_sent`=0x0000 with `frame_done` pulsed.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_arbiter_if                                              |
// | Brief    : Requester/transmitter bundle between readout FSMs and uart_tx.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   grant;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               tx_busy;
  logic               frame_done;
  logic [15:0]        frames_sent;

  modport master (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, grant, tx_start, tx_data, frame_done, frames_sent
  );

  modport slave (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, grant, tx_start, tx_data, frame_done, frames_sent
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_arbiter                                                 |
// | Brief    : Round-robin frame arbiter pacing bytes into a single uart_tx.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  wire logic         clk,
  input  wire logic         reset,
  uart_tx_arbiter_if.master bus
);

  localparam int c_IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int c_TMR_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [c_TMR_W-1:0] c_TMR_MAX = c_TMR_W'(BUSY_TIMEOUT);
  localparam logic [N_REQ-1:0]   c_ONE     = N_REQ'(1);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARB     = 3'd1,
    S_LOAD    = 3'd2,
    S_SEND    = 3'd3,
    S_WAIT_HI = 3'd4,
    S_WAIT_LO = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t             r_state;
  logic [N_REQ-1:0]   r_grant;
  logic [c_IDX_W-1:0] r_g;
  logic [c_IDX_W-1:0] r_rr_ptr;
  logic [N_REQ-1:0]   r_req_ready;
  logic               r_tx_start;
  logic [7:0]         r_tx_data;
  logic               r_frame_done;
  logic [15:0]        r_frames_sent;
  logic               r_last_q;
  logic [c_TMR_W-1:0] r_timer;
  logic [N_REQ-1:0]   r_snap;

  logic [N_REQ-1:0]   w_cand;
  logic [c_IDX_W-1:0] w_scan_idx;
  logic [c_IDX_W-1:0] w_win;
  logic               w_found;
  logic [c_TMR_W-1:0] w_timer_next;

  // Snapshot from IDLE keeps a requester eligible even if it drops during ARB.
  assign w_cand       = bus.req_valid | r_snap;
  assign w_timer_next = r_timer + 1'b1;

  always_comb begin
    w_found    = 1'b0;
    w_win      = '0;
    w_scan_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_scan_idx = c_IDX_W'((int'(r_rr_ptr) + 1 + k) % N_REQ);
      if (!w_found && w_cand[w_scan_idx]) begin
        w_found = 1'b1;
        w_win   = w_scan_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_g           <= '0;
      r_rr_ptr      <= c_LAST_IDX;
      r_req_ready   <= '0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= 8'h00;
      r_frame_done  <= 1'b0;
      r_frames_sent <= 16'h0000;
      r_last_q      <= 1'b0;
      r_timer       <= '0;
      r_snap        <= '0;
    end else begin
      r_req_ready  <= '0;
      r_tx_start   <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_grant <= '0;
          r_snap  <= bus.req_valid;
          if (|bus.req_valid) r_state <= S_ARB;
        end
        S_ARB: begin
          if (w_found) begin
            r_g     <= w_win;
            r_grant <= c_ONE << w_win;
            r_state <= S_LOAD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LOAD: begin
          if (bus.req_valid[r_g]) begin
            r_req_ready <= r_grant;
            r_tx_data   <= bus.req_data[{r_g, 3'b000} +: 8];
            r_last_q    <= bus.req_last[r_g];
            r_state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (!bus.tx_busy) begin
            r_tx_start <= 1'b1;
            r_timer    <= '0;
            r_state    <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          // A transmitter that never raises busy is assumed to have sent the byte.
          if (bus.tx_busy) begin
            r_state <= S_WAIT_LO;
          end else begin
            r_timer <= w_timer_next;
            if (w_timer_next == c_TMR_MAX) r_state <= S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          if (!bus.tx_busy) r_state <= r_last_q ? S_DONE : S_LOAD;
        end
        S_DONE: begin
          r_frame_done  <= 1'b1;
          r_frames_sent <= r_frames_sent + 16'd1;
          r_rr_ptr      <= r_g;
          r_grant       <= '0;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.grant       = r_grant;
  assign bus.tx_start    = r_tx_start;
  assign bus.tx_data     = r_tx_data;
  assign bus.frame_done  = r_frame_done;
  assign bus.frames_sent = r_frames_sent;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_tx_arbiter                                              |
// | Brief    : Directed self-checking bench for uart_tx_arbiter.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(.N_REQ(N), .BUSY_TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Requester byte queues: {last, data}
  logic [8:0]   mem [N][32];
  int           wr [N];
  int           rd [N];
  logic [N-1:0] stall;

  for (genvar i = 0; i < N; i++) begin : g_req
    assign bus.req_valid[i]        = (rd[i] < wr[i]) && !stall[i];
    assign bus.req_data[8*i +: 8]  = mem[i][rd[i][4:0]][7:0];
    assign bus.req_last[i]         = mem[i][rd[i][4:0]][8];
  end

  // UART model: busy for uart_len cycles after tx_start; uart_len=0 never busy
  int uart_len;
  int busy_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset)                          busy_cnt <= 0;
    else if (bus.tx_start && uart_len > 0) busy_cnt <= uart_len;
    else if (busy_cnt > 0)               busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_busy = (busy_cnt != 0);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / feeder
  logic [7:0] log_data [64];
  int         log_gnt  [64];
  int         log_cyc  [64];
  int         n_tx = 0;
  int         rdy_cnt [N];
  int         fd_cnt = 0;
  int         fd_cyc = 0;
  int         proto_err = 0;

  function automatic int oh2idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (bus.tx_start && n_tx < 64) begin
      log_data[n_tx] = bus.tx_data;
      log_gnt[n_tx]  = oh2idx(bus.grant);
      log_cyc[n_tx]  = cyc;
      n_tx++;
    end
    for (int i = 0; i < N; i++) begin
      if (bus.req_ready[i]) begin
        rdy_cnt[i]++;
        rd[i]++;
      end
    end
    if (bus.frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if ($countones(bus.grant) > 1 || $countones(bus.req_ready) > 1 ||
        (bus.req_ready & ~bus.grant) != '0)
      proto_err++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic last);
    mem[r][wr[r] % 32] = {last, d};
    wr[r]++;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int k = 0;
    while (fd_cnt < target && k < budget) begin
      tick();
      k++;
    end
    check("frame_wait", fd_cnt, target);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    stall = '0;
    for (int i = 0; i < N; i++) begin
      wr[i] = 0;
      rd[i] = 0;
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, fdb, k, r0, r3;
    logic [7:0] exp_b [6];
    int         exp_g [6];

    for (int i = 0; i < N; i++) begin
      wr[i] = 0; rd[i] = 0; rdy_cnt[i] = 0;
      for (int j = 0; j < 32; j++) mem[i][j] = '0;
    end
    stall    = '0;
    uart_len = 10;
    tick();
    tick();

    // Reset state
    check("rst_grant",       bus.grant,       0);
    check("rst_req_ready",   bus.req_ready,   0);
    check("rst_tx_start",    bus.tx_start,    0);
    check("rst_tx_data",     bus.tx_data,     0);
    check("rst_frame_done",  bus.frame_done,  0);
    check("rst_frames_sent", bus.frames_sent, 0);
    reset = 1'b1;
    tick();
    tick();

    // Single requester, 4-byte frame, 10-cycle UART
    base = n_tx;
    push(1, 8'h11, 1'b0); push(1, 8'h22, 1'b0); push(1, 8'h33, 1'b0); push(1, 8'h44, 1'b1);
    tick();
    tick();
    check("lat_grant",    bus.grant,     4'b0010);
    check("lat_no_ready", bus.req_ready, 0);
    tick();
    check("lat_ready",    bus.req_ready, 4'b0010);
    check("lat_tx_data",  bus.tx_data,   8'h11);
    tick();
    check("lat_tx_start", bus.tx_start,  1);
    wait_frames(1, 300);
    check("single_tx_count", n_tx - base, 4);
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      check("single_tx_data", log_data[base+i], exp_b[i]);
      check("single_grant",   log_gnt[base+i],  1);
    end
    check("single_byte_gap", log_cyc[base+1] - log_cyc[base], 14);
    check("single_ready1",   rdy_cnt[1], 4);
    check("single_ready_others", rdy_cnt[0] + rdy_cnt[2] + rdy_cnt[3], 0);
    check("single_fd_count", fd_cnt, 1);
    check("single_frames_sent", bus.frames_sent, 1);

    // Simultaneous requests after reset: 0 before 2, then rr_ptr=2 favours 3
    do_reset();
    base = n_tx; fdb = fd_cnt;
    push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1);
    push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b1);
    wait_frames(fdb + 2, 400);
    exp_b[0] = 8'hA0; exp_b[1] = 8'hA1; exp_b[2] = 8'hC0; exp_b[3] = 8'hC1;
    exp_g[0] = 0; exp_g[1] = 0; exp_g[2] = 2; exp_g[3] = 2;
    for (int i = 0; i < 4; i++) begin
      check("simul_tx_data", log_data[base+i], exp_b[i]);
      check("simul_grant",   log_gnt[base+i],  exp_g[i]);
    end
    push(3, 8'hD3, 1'b1); push(2, 8'hC2, 1'b1);
    wait_frames(fdb + 4, 400);
    check("rrptr_next_grant3", log_gnt[base+4], 3);
    check("rrptr_then_grant2", log_gnt[base+5], 2);
    check("simul_frames_sent", bus.frames_sent, 4);

    // Round-robin fairness with single-byte frames
    do_reset();
    uart_len = 2;
    base = n_tx; fdb = fd_cnt;
    push(0, 8'h80, 1'b1); push(0, 8'h81, 1'b1);
    push(1, 8'h90, 1'b1); push(1, 8'h91, 1'b1);
    push(2, 8'hA0, 1'b1);
    push(3, 8'hB0, 1'b1);
    wait_frames(fdb + 6, 400);
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 2; exp_g[3] = 3; exp_g[4] = 0; exp_g[5] = 1;
    exp_b[0] = 8'h80; exp_b[1] = 8'h90; exp_b[2] = 8'hA0; exp_b[3] = 8'hB0;
    exp_b[4] = 8'h81; exp_b[5] = 8'h91;
    for (int i = 0; i < 6; i++) begin
      check("rr_grant",   log_gnt[base+i],  exp_g[i]);
      check("rr_tx_data", log_data[base+i], exp_b[i]);
    end

    // Stall mid-frame with tx_busy stuck low (timeout path)
    uart_len = 0;
    base = n_tx; fdb = fd_cnt;
    r3 = rdy_cnt[3];
    push(3, 8'hE0, 1'b0);
    k = 0;
    while (rdy_cnt[3] == r3 && k < 50) begin
      tick();
      k++;
    end
    check("stall_first_ready", rdy_cnt[3] - r3, 1);
    stall[3] = 1'b1;
    push(3, 8'hE1, 1'b0); push(3, 8'hE2, 1'b1);
    push(0, 8'h70, 1'b1);
    r0 = rdy_cnt[0];
    for (int i = 0; i < 20; i++) tick();
    check("stall_grant_held", bus.grant, 4'b1000);
    check("stall_other_ignored", rdy_cnt[0] - r0, 0);
    stall[3] = 1'b0;
    wait_frames(fdb + 1, 300);
    check("stall_tx_b0", log_data[base],   8'hE0);
    check("stall_tx_b1", log_data[base+1], 8'hE1);
    check("stall_tx_b2", log_data[base+2], 8'hE2);
    check("timeout_byte_gap", log_cyc[base+2] - log_cyc[base+1], 18);
    check("timeout_fd_delay", fd_cyc - log_cyc[base+2], 17);
    wait_frames(fdb + 2, 300);
    check("after_stall_grant0", log_gnt[base+3], 0);

    // Reset during WAIT_HI of byte 2 of a 3-byte frame
    base = n_tx;
    push(1, 8'hF0, 1'b0); push(1, 8'hF1, 1'b0); push(1, 8'hF2, 1'b1);
    k = 0;
    while (n_tx < base + 2 && k < 100) begin
      tick();
      k++;
    end
    check("midrst_reached_b2", n_tx - base, 2);
    reset = 1'b0;
    #1;
    check("midrst_tx_start",    bus.tx_start,    0);
    check("midrst_grant",       bus.grant,       0);
    check("midrst_req_ready",   bus.req_ready,   0);
    check("midrst_tx_data",     bus.tx_data,     0);
    check("midrst_frame_done",  bus.frame_done,  0);
    check("midrst_frames_sent", bus.frames_sent, 0);
    for (int i = 0; i < N; i++) begin
      wr[i] = 0;
      rd[i] = 0;
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    base = n_tx; fdb = fd_cnt;
    uart_len = 2;
    push(2, 8'h52, 1'b1); push(0, 8'h50, 1'b1);
    wait_frames(fdb + 2, 300);
    check("postrst_first_grant0",  log_gnt[base],   0);
    check("postrst_second_grant2", log_gnt[base+1], 2);
    check("postrst_frames_sent",   bus.frames_sent, 2);

    // frames_sent wrap
    force dut.r_frames_sent = 16'hFFFF;
    tick();
    release dut.r_frames_sent;
    tick();
    check("wrap_preload", bus.frames_sent, 16'hFFFF);
    base = n_tx; fdb = fd_cnt;
    push(1, 8'h99, 1'b1);
    wait_frames(fdb + 1, 300);
    check("wrap_tx_data",     log_data[base],  8'h99);
    check("wrap_frames_sent", bus.frames_sent, 16'h0000);

    check("protocol_errors", proto_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
